// File: rtl/ce_prescaler_if.sv
// ----------------------------------------------------------------------------
// ce_prescaler_if
//   Control/status bundle for the ce_prescaler clock-enable generator.
//   master : the controller (drives run/div_load/div_in/step, observes ce/running)
//   slave  : the prescaler itself
// Signals
//   run      level, 1 = generate periodic ce
//   div_load one-cycle strobe, capture div_in into the divider register
//   div_in   new divider value (0 behaves as 1)
//   step     single-step request, rising-edge detected inside the prescaler
//   ce       registered enable pulse, one cycle wide
//   running  registered, 1 while the prescaler is in its RUN state
// ----------------------------------------------------------------------------
interface ce_prescaler_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             run;
  logic             div_load;
  logic [CNT_W-1:0] div_in;
  logic             step;
  logic             ce;
  logic             running;

  modport master (
    output run,
    output div_load,
    output div_in,
    output step,
    input  ce,
    input  running
  );

  modport slave (
    input  run,
    input  div_load,
    input  div_in,
    input  step,
    output ce,
    output running
  );

endinterface : ce_prescaler_if

// File: rtl/ce_prescaler.sv
// ----------------------------------------------------------------------------
// ce_prescaler
//   Clock-enable generator: divides the system clock into one-cycle ce pulses
//   every div_eff cycles (div_eff = div_reg, with 0 treated as 1). Feeds the ce
//   input of cntr_2 and other ce-gated counters. Single clock domain, no
//   derived clocks.
//
// Parameters
//   CNT_W        width of the divider register and internal counter
//   DIV_DEFAULT  divider value loaded at reset (>=1, fits in CNT_W)
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   ce_prescaler_if.slave: run, div_load, div_in, step -> ce, running
//
// Build option
//   CE_PRESCALER_STEP_EN  when defined, a rising edge on step while idle with
//                         run=0 emits exactly one ce pulse (STEP state). When
//                         undefined the step input is ignored and neither the
//                         STEP state nor the step edge register is built.
//
// Edge priority: rst > div_load > run=0 stop > terminal count > increment.
// ----------------------------------------------------------------------------
module ce_prescaler #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 10
) (
  input  logic            clk,
  input  logic            rst,
  ce_prescaler_if.slave   bus
);

`ifdef CE_PRESCALER_STEP_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP
  } state_t;
`else
  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_reg_q, div_reg_d;
  logic             ce_q, ce_d;
  logic             running_q, running_d;

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] div_eff_m1;
  logic             terminal;

`ifdef CE_PRESCALER_STEP_EN
  logic             step_q;
  logic             step_rise;

  assign step_rise = bus.step & ~step_q;
`else
  logic             unused_step;

  assign unused_step = bus.step;
`endif

  assign div_eff    = (div_reg_q == '0) ? CNT_W'(1) : div_reg_q;
  assign div_eff_m1 = div_eff - CNT_W'(1);
  assign terminal   = (cnt_q == div_eff_m1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_reg_d = div_reg_q;
    ce_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.run) begin
          state_d = S_RUN;
`ifdef CE_PRESCALER_STEP_EN
        // A load on the same edge suppresses the step so STEP always
        // carries its ce pulse.
        end else if (step_rise && !bus.div_load) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
`endif
        end
      end

      S_RUN: begin
        if (!bus.run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (terminal) begin
          cnt_d = '0;
          ce_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef CE_PRESCALER_STEP_EN
      S_STEP: begin
        cnt_d   = '0;
        state_d = bus.run ? S_RUN : S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Load wins over stop/terminal: restart the count and drop the pulse,
    // while the state transition above still takes effect.
    if (bus.div_load) begin
      div_reg_d = bus.div_in;
      cnt_d     = '0;
      ce_d      = 1'b0;
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_reg_q <= CNT_W'(DIV_DEFAULT);
      ce_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_reg_q <= div_reg_d;
      ce_q      <= ce_d;
      running_q <= running_d;
    end
  end

`ifdef CE_PRESCALER_STEP_EN
  // Edge history is tracked in every state so a step held across RUN
  // does not fire when the prescaler returns to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end
`endif

  assign bus.ce      = ce_q;
  assign bus.running = running_q;

  cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= div_eff_m1);

endmodule : ce_prescaler

// File: tb/tb_ce_prescaler.sv
// ----------------------------------------------------------------------------
// tb_ce_prescaler
//   Directed bench for ce_prescaler (CNT_W=16, DIV_DEFAULT=10) with a 2-bit
//   model of cntr_2 counting the ce pulses. Inputs change 1 time unit after a
//   rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_ce_prescaler;

  localparam int unsigned CNT_W = 16;

  logic       clk;
  logic       rst;
  logic [1:0] cnt2 = 2'd0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ce_prescaler_if #(.CNT_W(CNT_W)) bus ();

  ce_prescaler #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cntr_2 stand-in: 2-bit counter advanced by ce, not cleared by rst.
  always @(posedge clk) begin
    if (bus.ce === 1'b1) cnt2 <= cnt2 + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting from cnt=0, expect ce low for div-1 edges and high after the div-th.
  task automatic period(input int unsigned div, input string tag);
    for (int unsigned i = 1; i <= div; i++) begin
      tick();
      check(tag, {31'd0, bus.ce}, {31'd0, (i == div)});
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.run      = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    bus.step     = 1'b0;

    // Reset
    #2 rst = 1'b1;
    #1;
    check("rst_ce", {31'd0, bus.ce}, 32'd0);
    check("rst_running", {31'd0, bus.running}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    check("rst_div_reg", {16'd0, dut.div_reg_q}, 32'd10);
    check("rst_cnt", {16'd0, dut.cnt_q}, 32'd0);

    // Run with default divider: ce on the 10th edge after entry, then every 10
    bus.run = 1'b1;
    tick();
    check("entry_running", {31'd0, bus.running}, 32'd1);
    check("entry_ce", {31'd0, bus.ce}, 32'd0);
    period(10, "div10_p1");
    check("cntr2_a", {30'd0, cnt2}, 32'd0);
    period(10, "div10_p2");
    check("cntr2_b", {30'd0, cnt2}, 32'd1);
    period(10, "div10_p3");
    check("cntr2_c", {30'd0, cnt2}, 32'd2);
    period(10, "div10_p4");
    check("cntr2_d", {30'd0, cnt2}, 32'd3);

    // Load div_in=3 on the terminal edge: pulse suppressed, count restarts
    for (int unsigned i = 0; i < 9; i++) begin
      tick();
      check("div10_pre_load", {31'd0, bus.ce}, 32'd0);
    end
    check("cnt_at_9", {16'd0, dut.cnt_q}, 32'd9);
    bus.div_load = 1'b1;
    bus.div_in   = 16'd3;
    tick();
    bus.div_load = 1'b0;
    check("load3_ce", {31'd0, bus.ce}, 32'd0);
    check("load3_div_reg", {16'd0, dut.div_reg_q}, 32'd3);
    check("load3_cnt", {16'd0, dut.cnt_q}, 32'd0);
    check("cntr2_wrap", {30'd0, cnt2}, 32'd0);
    period(3, "div3_p1");
    period(3, "div3_p2");
    period(3, "div3_p3");

    // div_in=0 behaves as 1: ce every cycle
    bus.div_load = 1'b1;
    bus.div_in   = 16'd0;
    tick();
    bus.div_load = 1'b0;
    check("load0_ce", {31'd0, bus.ce}, 32'd0);
    period(1, "div0_p1");
    period(1, "div0_p2");
    period(1, "div0_p3");

    // Stop on a terminal edge: no pulse, counter cleared
    bus.run = 1'b0;
    tick();
    check("stop_ce", {31'd0, bus.ce}, 32'd0);
    check("stop_running", {31'd0, bus.running}, 32'd0);
    check("stop_cnt", {16'd0, dut.cnt_q}, 32'd0);
    tick();
    check("idle_ce", {31'd0, bus.ce}, 32'd0);

    // Load while idle, then run with div_in=1
    bus.div_load = 1'b1;
    bus.div_in   = 16'd1;
    tick();
    bus.div_load = 1'b0;
    check("load1_idle_ce", {31'd0, bus.ce}, 32'd0);
    check("load1_div_reg", {16'd0, dut.div_reg_q}, 32'd1);
    bus.run = 1'b1;
    tick();
    check("div1_running", {31'd0, bus.running}, 32'd1);
    check("div1_entry_ce", {31'd0, bus.ce}, 32'd0);
    period(1, "div1_p1");
    period(1, "div1_p2");

    // Load and run falling on the same edge
    bus.run      = 1'b0;
    bus.div_load = 1'b1;
    bus.div_in   = 16'd5;
    tick();
    bus.div_load = 1'b0;
    check("loadstop_running", {31'd0, bus.running}, 32'd0);
    check("loadstop_ce", {31'd0, bus.ce}, 32'd0);
    check("loadstop_div_reg", {16'd0, dut.div_reg_q}, 32'd5);
    tick();
    check("loadstop_idle_ce", {31'd0, bus.ce}, 32'd0);

    // Run with div 5, then reset asynchronously while ce is high
    bus.run = 1'b1;
    tick();
    check("div5_running", {31'd0, bus.running}, 32'd1);
    period(5, "div5_p1");
    period(5, "div5_p2");
    rst = 1'b1;
    #1;
    check("async_rst_ce", {31'd0, bus.ce}, 32'd0);
    check("async_rst_running", {31'd0, bus.running}, 32'd0);
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    check("post_rst_div_reg", {16'd0, dut.div_reg_q}, 32'd10);
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      check("post_rst_ce", {31'd0, bus.ce}, 32'd0);
    end
    // 13 pulses reached cntr_2 before the reset (the one cut short never did)
    check("cntr2_hold", {30'd0, cnt2}, 32'd1);

    // Step pulses, each held high for two edges, with run=0
    for (int unsigned n = 0; n < 3; n++) begin
      bus.step = 1'b1;
      tick();
`ifdef CE_PRESCALER_STEP_EN
      check("step_pulse", {31'd0, bus.ce}, 32'd1);
`else
      check("step_ignored", {31'd0, bus.ce}, 32'd0);
`endif
      check("step_running", {31'd0, bus.running}, 32'd0);
      tick();
      check("step_after", {31'd0, bus.ce}, 32'd0);
      bus.step = 1'b0;
      tick();
      check("step_low1", {31'd0, bus.ce}, 32'd0);
      tick();
      check("step_low2", {31'd0, bus.ce}, 32'd0);
    end

    // Step held high while running: only periodic pulses
    bus.step = 1'b1;
    bus.run  = 1'b1;
    tick();
    check("step_run_entry_ce", {31'd0, bus.ce}, 32'd0);
    check("step_run_running", {31'd0, bus.running}, 32'd1);
    period(10, "step_run_p1");
    period(10, "step_run_p2");
    bus.run = 1'b0;
    tick();
    check("step_run_stop_ce", {31'd0, bus.ce}, 32'd0);
    tick();
    check("step_held_idle_ce", {31'd0, bus.ce}, 32'd0);
    bus.step = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ce_prescaler
